// File: rtl/flag_pkg.sv
// Shared definitions for the Z/V/N flag unit:
// opcodes, flag bit positions, EX entry type, FSM states.
package flag_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_XOR = 4'b0010;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRA = 4'b0101;
  localparam logic [3:0] OP_ROR = 4'b0110;
  localparam logic [3:0] OP_LW  = 4'b1000;
  localparam logic [3:0] OP_SW  = 4'b1001;
  localparam logic [3:0] OP_LHB = 4'b1010;
  localparam logic [3:0] OP_LLB = 4'b1011;
  localparam logic [3:0] OP_B   = 4'b1100;
  localparam logic [3:0] OP_BR  = 4'b1101;
  localparam logic [3:0] OP_PCS = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  localparam int Z_BIT = 2;
  localparam int V_BIT = 1;
  localparam int N_BIT = 0;

  typedef struct packed {
    logic       valid;
    logic [3:0] opcode;
  } ex_entry_t;

  typedef enum logic {
    RUN,
    HALTED
  } state_t;

  function automatic logic [2:0] flag_mask(
    input logic [3:0] op
  );
    logic [2:0] m;
    m = 3'b000;
    unique case (1'b1)
      (op == OP_ADD) || (op == OP_SUB):
        m = 3'b111;
      (op == OP_XOR) || (op == OP_SLL) ||
      (op == OP_SRA) || (op == OP_ROR):
        m = 3'b100;
      default:
        m = 3'b000;
    endcase
    return m;
  endfunction

  function automatic logic is_branch(
    input logic [3:0] op
  );
    return (op == OP_B) || (op == OP_BR);
  endfunction

endpackage

// File: rtl/flag_unit_calc.sv
// Combinational flag merge: fresh ALU flags where
// the mask is set, committed flags elsewhere.
module flag_calc
  import flag_pkg::*;
(
  input  logic [15:0] alu_result,
  input  logic        alu_ovfl,
  input  logic [2:0]  mask,
  input  logic [2:0]  f,
  output logic [2:0]  f_next
);

  logic [2:0] val;

  assign val[Z_BIT] = (alu_result == 16'h0000);
  assign val[V_BIT] = alu_ovfl;
  assign val[N_BIT] = alu_result[15];

  assign f_next = (mask & val) | (~mask & f);

endmodule

// File: rtl/flag_unit.sv
// Z/V/N flag register with EX tracking, decode
// bypass/hazard generation and HLT freeze.
module flag_unit
  import flag_pkg::*;
#(
  parameter bit BYPASS = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [3:0]  id_opcode,
  input  logic        stall,
  input  logic        flush,
  input  logic [15:0] alu_result,
  input  logic        alu_ovfl,
  output logic [2:0]  f,
  output logic [2:0]  f_branch,
  output logic        branch_hazard,
  output logic        halted
);

  ex_entry_t  ex;
  state_t     state;
  logic [2:0] mask;
  logic [2:0] f_next;
  logic       run;
  logic       advance;
  logic       ex_writes;

  assign run     = (state == RUN);
  assign advance = run & ~stall;

  // Once halted the EX entry is dead; it must not leak via bypass.
  assign mask = (ex.valid && run) ? flag_mask(ex.opcode) : 3'b000;
  assign ex_writes = |mask;

  flag_calc u_calc (
    .alu_result (alu_result),
    .alu_ovfl   (alu_ovfl),
    .mask       (mask),
    .f          (f),
    .f_next     (f_next)
  );

  assign f_branch = (BYPASS && ex_writes) ? f_next : f;

  assign branch_hazard = !BYPASS && id_valid &&
                         is_branch(id_opcode) && ex_writes;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f      <= 3'b000;
      ex     <= '0;
      state  <= RUN;
      halted <= 1'b0;
    end else if (advance) begin
      f <= f_next;
      if (flush || !id_valid) begin
        ex <= '0;
      end else begin
        ex.valid  <= 1'b1;
        ex.opcode <= id_opcode;
      end
      if (ex.valid && ex.opcode == OP_HLT) begin
        state  <= HALTED;
        halted <= 1'b1;
      end
    end
  end

endmodule

// File: doc/flag_unit.md
# flag_unit

Owns the Z/V/N condition-flag register that the next-PC/branch logic reads as its 3-bit flag input. It tracks the EX-stage instruction, commits flags from ALU results per opcode class, provides a same-cycle bypass of in-flight flag values to decode-stage branches, and freezes state on HLT. It sits between the EX-stage ALU and the decode-stage branch resolver.

## Interface
- BYPASS, 1: 1 = decode branches may use EX-stage flags in the same cycle; 0 = no bypass, stall instead.
- clk  input  1  core clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- id_valid  input  1  decode stage holds a real instruction
- id_opcode  input  4  decode-stage opcode [15:12]
- stall  input  1  hold EX stage and flags this cycle
- flush  input  1  squash decode instruction on its way into EX
- alu_result  input  16  ALU output for the current EX instruction
- alu_ovfl  input  1  signed overflow from the ALU for the current EX instruction
- f  output  3  committed flags {Z,V,N}; f[2]=Z, f[1]=V, f[0]=N
- f_branch  output  3  flags a decode branch must use (bypassed or committed)
- branch_hazard  output  1  decode branch must stall one cycle
- halted  output  1  HLT has committed

## Operation
- Opcode classes (package): ADD 0000 and SUB 0001 write Z, V, N. XOR 0010, SLL 0100, SRA 0101, ROR 0110 write Z only. All others write nothing. B 1100 and BR 1101 are branches. HLT is 1111.
- Flag values: Z = (alu_result == 16'h0); N = alu_result[15]; V = alu_ovfl. Flags not written keep their value.
- EX tracking register holds {ex_valid, ex_opcode}. On each edge with !stall: EX <= (flush | !id_valid) ? bubble : {1, id_opcode}.
- Commit: on an edge with ex_valid & !stall & state RUN, the masked flag write for ex_opcode is applied to f.
- ex_writes = ex_valid & opcode class writes ≥1 flag.
- f_next is f with the current EX write applied, computed combinationally.
- f_branch = (BYPASS & ex_writes) ? f_next : f.
- branch_hazard = id_valid & id_opcode is branch & ex_writes & !BYPASS. It is always 0 when BYPASS=1.
- FSM RUN -> HALTED on an edge with ex_valid & ex_opcode==HLT & !stall. HALTED is terminal until reset.
- In HALTED: f frozen, EX register holds, branch_hazard=0, halted=1.
- stall & flush together: stall wins. Nothing updates and flush is dropped; the pipeline controller holds flush.

## Timing
- Reset (async assert, sync-released use): f=3'b000, EX=bubble, state=RUN, halted=0, f_branch=3'b000, branch_hazard=0.
- Commit latency: an EX-stage flag writer is visible on f one cycle after the edge where EX advances. It is visible on f_branch in the same cycle (BYPASS=1).
- BYPASS=0: a branch directly behind a flag writer sees branch_hazard=1 for exactly one cycle if no stall. The next cycle EX holds a bubble, so hazard drops and f_branch=f carries the committed value.
- Stall with a writer in EX: f unchanged, hazard/bypass persist while stalled.
- Reset mid-stall or mid-halt: returns immediately to reset values.
- halted asserts the cycle after the HLT commit edge.

## Structure
- Package flag_pkg: opcode localparams (ADD…HLT), Z/V/N bit indices, typedef for the {valid, opcode} EX entry, FSM enum {RUN, HALTED}, and function flag_mask(opcode) returning the 3-bit write mask.
- Sub-module flag_calc (combinational): alu_result, alu_ovfl, mask, f → f_next. The same instance feeds both the register and the bypass.

## Test plan
- Reset, then ADD in EX with alu_result=16'h0000, ovfl=0 → f_branch=3'b100 same cycle; f=3'b100 next cycle.
- f=3'b100, then XOR with result 16'h8001, ovfl=1 → only Z cleared; f=3'b000 (V, N untouched).
- SUB with result 16'h8000, ovfl=1, stall held 3 cycles → f unchanged during stall; f=3'b011 after stall releases.
- BYPASS=0: ADD in EX and B in ID → branch_hazard=1 for one cycle, then 0 with f_branch equal to committed ADD flags.
- LW/SW/LLB in EX with arbitrary ALU values → f never changes. flush with ADD in ID → ADD never commits.
- HLT commits then SUB presented → halted=1, f frozen. rst_n low mid-halt → all outputs return to reset values asynchronously.
